// File: rtl/change_dispenser_if.sv
// Handshake, request and stock-refill signals between the vending controller
// and the change dispenser.
interface change_dispenser_if #(
  parameter int N = 7,
  parameter int D = 6
);
  logic         i_valid;
  logic [D-1:0] i_item;
  logic [N-1:0] i_change;
  logic         busy;
  logic         item_valid;
  logic [D-1:0] item_code;
  logic         item_ready;
  logic         note_valid;
  logic [N-1:0] note_denom;
  logic         note_ready;
  logic         done;
  logic         short;
  logic [N-1:0] short_amt;
  logic         refill_valid;
  logic [2:0]   refill_sel;
  logic [7:0]   refill_cnt;
  logic [7:0]   stock_lvl;

  modport slave (
    input  i_valid, i_item, i_change, item_ready, note_ready,
           refill_valid, refill_sel, refill_cnt,
    output busy, item_valid, item_code, note_valid, note_denom,
           done, short, short_amt, stock_lvl
  );

  modport master (
    output i_valid, i_item, i_change, item_ready, note_ready,
           refill_valid, refill_sel, refill_cnt,
    input  busy, item_valid, item_code, note_valid, note_denom,
           done, short, short_amt, stock_lvl
  );
endinterface

// File: rtl/change_dispenser.sv
// Drops an item, then pays change greedily from six stocked note denominations;
// reports any unpaid remainder with the end-of-transaction pulse.
module change_dispenser #(
  parameter int N = 7,
  parameter int D = 6
) (
  input  logic             clk,
  input  logic             rstn,
  change_dispenser_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ITEM, CHANGE, DONE} state_t;

  state_t       state, state_d;
  logic [D-1:0] item_q;
  logic [N-1:0] rem_q;
  logic [7:0]   stock [6];

  logic         found;
  logic [2:0]   sel;
  logic [N-1:0] sel_denom;
  logic [N-1:0] rem_next;
  logic         note_hs;
  logic [8:0]   refill_sum;
  logic [7:0]   refill_val;

  function automatic logic [7:0] denom_of(input logic [2:0] idx);
    case (idx)
      3'd0:    denom_of = 8'd50;
      3'd1:    denom_of = 8'd20;
      3'd2:    denom_of = 8'd10;
      3'd3:    denom_of = 8'd5;
      3'd4:    denom_of = 8'd2;
      default: denom_of = 8'd1;
    endcase
  endfunction

  // Lowest index wins, i.e. largest payable note that is still in stock.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int unsigned i = 0; i < 6; i++) begin
      if (!found && (32'(denom_of(3'(i))) <= 32'(rem_q)) && (stock[i] != '0)) begin
        found = 1'b1;
        sel   = 3'(i);
      end
    end
    sel_denom = N'(denom_of(sel));
    rem_next  = rem_q - sel_denom;
  end

  always_comb begin
    bus.stock_lvl = '0;
    for (int unsigned i = 0; i < 6; i++) begin
      if (bus.refill_sel == 3'(i)) bus.stock_lvl = stock[i];
    end
    refill_sum = {1'b0, bus.stock_lvl} + {1'b0, bus.refill_cnt};
    refill_val = refill_sum[8] ? 8'hFF : refill_sum[7:0];
  end

  always_comb begin
    state_d = state;
    note_hs = 1'b0;
    case (state)
      IDLE: begin
        if (bus.i_valid) begin
          if (bus.i_item != '0)        state_d = ITEM;
          else if (bus.i_change != '0) state_d = CHANGE;
          else                         state_d = DONE;
        end
      end
      ITEM: begin
        if (bus.item_ready) state_d = (rem_q != '0) ? CHANGE : DONE;
      end
      CHANGE: begin
        if (!found) begin
          state_d = DONE;
        end else if (bus.note_ready) begin
          note_hs = 1'b1;
          if (rem_next == '0) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy       = (state != IDLE);
    bus.item_valid = (state == ITEM);
    bus.item_code  = (state == ITEM) ? item_q : '0;
    bus.note_valid = (state == CHANGE) && found;
    bus.note_denom = ((state == CHANGE) && found) ? sel_denom : '0;
    bus.done       = (state == DONE);
    bus.short      = (state == DONE) && (rem_q != '0);
    bus.short_amt  = (state == DONE) ? rem_q : '0;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state  <= IDLE;
      item_q <= '0;
      rem_q  <= '0;
      for (int unsigned i = 0; i < 6; i++) stock[i] <= '0;
    end else begin
      state <= state_d;
      if (state == IDLE && bus.i_valid) begin
        item_q <= bus.i_item;
        rem_q  <= bus.i_change;
      end
      if (note_hs) rem_q <= rem_next;
      // Refill and note payout never coincide: refill is IDLE-only, payout CHANGE-only.
      for (int unsigned i = 0; i < 6; i++) begin
        if (state == IDLE && bus.refill_valid && bus.refill_sel == 3'(i))
          stock[i] <= refill_val;
        else if (note_hs && sel == 3'(i))
          stock[i] <= stock[i] - 8'd1;
      end
    end
  end

endmodule
